axi_rd_id_remapper: RTL and testbench

Read-channel ID compressor placed directly upstream of `axi_filter_rd_channel`. It maps wide AXI AR IDs onto a small set of slot IDs so that the filter's in-flight-ID check on the low ID bits never aliases between unrelated masters. On the R channel it restores the original ID. It tracks outstanding bursts per slot and stalls AR when no slot is available.

---
 rtl/axi_rd_id_remapper.sv | 187 ++++++++++++++++++
 tb/tb_axi_rd_id_remapper.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_id_remapper.sv
// axi_rd_id_remapper
//   Compresses wide AXI read IDs onto a small set of slot IDs and restores the
//   original ID on the R channel. Each slot remembers the original ID and counts
//   its outstanding bursts. AR is stalled when no slot can take the request.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   axi_in_ar_*             upstream AR (wide ID)
//   axi_out_ar_*            downstream AR (slot ID, other fields copied)
//   axi_out_r_*             downstream R (slot ID)
//   axi_in_r_*              upstream R (original ID restored, other fields copied)
module axi_rd_id_remapper #(
    parameter int unsigned AXI_ADDR_WIDTH   = 32,
    parameter int unsigned AXI_DATA_WIDTH   = 64,
    parameter int unsigned AXI_ID_IN_WIDTH  = 7,
    parameter int unsigned AXI_ID_OUT_WIDTH = 4,
    parameter int unsigned AXI_USER_WIDTH   = 4,
    parameter int unsigned NBR_SLOT         = 4,
    parameter int unsigned MAX_TXN_PER_ID   = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    // upstream AR
    input  logic                        axi_in_ar_valid_i,
    output logic                        axi_in_ar_ready_o,
    input  logic [AXI_ID_IN_WIDTH-1:0]  axi_in_ar_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_in_ar_addr_i,
    input  logic [2:0]                  axi_in_ar_prot_i,
    input  logic [3:0]                  axi_in_ar_region_i,
    input  logic [7:0]                  axi_in_ar_len_i,
    input  logic [2:0]                  axi_in_ar_size_i,
    input  logic [1:0]                  axi_in_ar_burst_i,
    input  logic                        axi_in_ar_lock_i,
    input  logic [3:0]                  axi_in_ar_cache_i,
    input  logic [3:0]                  axi_in_ar_qos_i,
    input  logic [AXI_USER_WIDTH-1:0]   axi_in_ar_user_i,
    // downstream AR
    output logic                        axi_out_ar_valid_o,
    input  logic                        axi_out_ar_ready_i,
    output logic [AXI_ID_OUT_WIDTH-1:0] axi_out_ar_id_o,
    output logic [AXI_ADDR_WIDTH-1:0]   axi_out_ar_addr_o,
    output logic [2:0]                  axi_out_ar_prot_o,
    output logic [3:0]                  axi_out_ar_region_o,
    output logic [7:0]                  axi_out_ar_len_o,
    output logic [2:0]                  axi_out_ar_size_o,
    output logic [1:0]                  axi_out_ar_burst_o,
    output logic                        axi_out_ar_lock_o,
    output logic [3:0]                  axi_out_ar_cache_o,
    output logic [3:0]                  axi_out_ar_qos_o,
    output logic [AXI_USER_WIDTH-1:0]   axi_out_ar_user_o,
    // downstream R
    input  logic                        axi_out_r_valid_i,
    output logic                        axi_out_r_ready_o,
    input  logic [AXI_ID_OUT_WIDTH-1:0] axi_out_r_id_i,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_out_r_data_i,
    input  logic [1:0]                  axi_out_r_resp_i,
    input  logic                        axi_out_r_last_i,
    input  logic [AXI_USER_WIDTH-1:0]   axi_out_r_user_i,
    // upstream R
    output logic                        axi_in_r_valid_o,
    input  logic                        axi_in_r_ready_i,
    output logic [AXI_ID_IN_WIDTH-1:0]  axi_in_r_id_o,
    output logic [AXI_DATA_WIDTH-1:0]   axi_in_r_data_o,
    output logic [1:0]                  axi_in_r_resp_o,
    output logic                        axi_in_r_last_o,
    output logic [AXI_USER_WIDTH-1:0]   axi_in_r_user_o
);

    localparam int unsigned SlotW = (NBR_SLOT > 1) ? $clog2(NBR_SLOT) : 1;
    localparam int unsigned CntW  = $clog2(MAX_TXN_PER_ID + 1);

    logic                       used_q   [NBR_SLOT];
    logic                       used_d   [NBR_SLOT];
    logic [AXI_ID_IN_WIDTH-1:0] orig_id_q[NBR_SLOT];
    logic [AXI_ID_IN_WIDTH-1:0] orig_id_d[NBR_SLOT];
    logic [CntW-1:0]            cnt_q    [NBR_SLOT];
    logic [CntW-1:0]            cnt_d    [NBR_SLOT];

    logic                       hit, free_avail, can_accept, r_slot_ok;
    logic [SlotW-1:0]           hit_idx, free_idx, sel_idx;
    logic [CntW-1:0]            hit_cnt;
    logic [AXI_ID_IN_WIDTH-1:0] r_orig_id;
    logic                       ar_hs, r_last_hs;

    // Slot lookup, all decoded from registered table state only.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        hit_cnt    = '0;
        free_avail = 1'b0;
        free_idx   = '0;
        r_slot_ok  = 1'b0;
        r_orig_id  = '0;
        for (int unsigned i = 0; i < NBR_SLOT; i++) begin
            if (used_q[i] && (orig_id_q[i] == axi_in_ar_id_i)) begin
                hit     = 1'b1;
                hit_idx = SlotW'(i);
                hit_cnt = cnt_q[i];
            end
            if (used_q[i] && (axi_out_r_id_i == AXI_ID_OUT_WIDTH'(i))) begin
                r_slot_ok = 1'b1;
                r_orig_id = orig_id_q[i];
            end
        end
        // Descending scan so the lowest free index wins.
        for (int i = int'(NBR_SLOT) - 1; i >= 0; i--) begin
            if (!used_q[i]) begin
                free_avail = 1'b1;
                free_idx   = SlotW'(i);
            end
        end
    end

    assign can_accept = hit ? (hit_cnt < CntW'(MAX_TXN_PER_ID)) : free_avail;
    assign sel_idx    = hit ? hit_idx : free_idx;

    assign axi_out_ar_valid_o  = axi_in_ar_valid_i && can_accept;
    assign axi_in_ar_ready_o   = axi_out_ar_ready_i && can_accept;
    assign axi_out_ar_id_o     = AXI_ID_OUT_WIDTH'(sel_idx);
    assign axi_out_ar_addr_o   = axi_in_ar_addr_i;
    assign axi_out_ar_prot_o   = axi_in_ar_prot_i;
    assign axi_out_ar_region_o = axi_in_ar_region_i;
    assign axi_out_ar_len_o    = axi_in_ar_len_i;
    assign axi_out_ar_size_o   = axi_in_ar_size_i;
    assign axi_out_ar_burst_o  = axi_in_ar_burst_i;
    assign axi_out_ar_lock_o   = axi_in_ar_lock_i;
    assign axi_out_ar_cache_o  = axi_in_ar_cache_i;
    assign axi_out_ar_qos_o    = axi_in_ar_qos_i;
    assign axi_out_ar_user_o   = axi_in_ar_user_i;

    assign axi_out_r_ready_o = axi_in_r_ready_i;
    assign axi_in_r_valid_o  = axi_out_r_valid_i;
    // Beats on unknown or idle slots are forwarded with ID zero.
    assign axi_in_r_id_o     = r_slot_ok ? r_orig_id : '0;
    assign axi_in_r_data_o   = axi_out_r_data_i;
    assign axi_in_r_resp_o   = axi_out_r_resp_i;
    assign axi_in_r_last_o   = axi_out_r_last_i;
    assign axi_in_r_user_o   = axi_out_r_user_i;

    assign ar_hs     = axi_in_ar_valid_i && axi_out_ar_ready_i && can_accept;
    assign r_last_hs = axi_out_r_valid_i && axi_in_r_ready_i && axi_out_r_last_i && r_slot_ok;

    always_comb begin
        for (int unsigned i = 0; i < NBR_SLOT; i++) begin
            logic inc, dec;
            used_d[i]    = used_q[i];
            orig_id_d[i] = orig_id_q[i];
            cnt_d[i]     = cnt_q[i];
            inc = ar_hs && (sel_idx == SlotW'(i));
            dec = r_last_hs && (axi_out_r_id_i == AXI_ID_OUT_WIDTH'(i));
            if (inc && !used_q[i]) begin
                // dec cannot coincide here: it requires the slot to be in use.
                used_d[i]    = 1'b1;
                orig_id_d[i] = axi_in_ar_id_i;
                cnt_d[i]     = CntW'(1);
            end else if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end else if (dec && !inc) begin
                cnt_d[i] = cnt_q[i] - CntW'(1);
                if (cnt_q[i] == CntW'(1)) begin
                    used_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < NBR_SLOT; i++) begin
                used_q[i]    <= 1'b0;
                orig_id_q[i] <= '0;
                cnt_q[i]     <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NBR_SLOT; i++) begin
                used_q[i]    <= used_d[i];
                orig_id_q[i] <= orig_id_d[i];
                cnt_q[i]     <= cnt_d[i];
            end
        end
    end

    // R beats must name a slot that is currently in use.
    r_slot_valid_a: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        axi_out_r_valid_i |-> r_slot_ok);

endmodule

// File: tb/tb_axi_rd_id_remapper.sv
// Self-checking bench for axi_rd_id_remapper: a slot-table model checked every
// cycle, plus directed scenarios with hand-computed slot IDs.
module tb_axi_rd_id_remapper;

    localparam int NS  = 4;
    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_ar_valid = 1'b0;
    logic [6:0]  in_ar_id = '0;
    logic [31:0] in_ar_addr = '0;
    logic [7:0]  in_ar_len = '0;
    logic        out_ar_ready = 1'b1;
    logic        out_r_valid = 1'b0;
    logic [3:0]  out_r_id = '0;
    logic [63:0] out_r_data = '0;
    logic [1:0]  out_r_resp = '0;
    logic        out_r_last = 1'b0;
    logic        in_r_ready = 1'b1;

    logic        ar_ready_o, ar_valid_o, r_ready_o, r_valid_o, r_last_o;
    logic [3:0]  ar_id_o;
    logic [31:0] ar_addr_o;
    logic [2:0]  ar_prot_o, ar_size_o;
    logic [3:0]  ar_region_o, ar_cache_o, ar_qos_o, ar_user_o, r_user_o;
    logic [7:0]  ar_len_o;
    logic [1:0]  ar_burst_o, r_resp_o;
    logic        ar_lock_o;
    logic [6:0]  r_id_o;
    logic [63:0] r_data_o;

    int n_tests = 0;
    int n_fail  = 0;

    axi_rd_id_remapper dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .axi_in_ar_valid_i  (in_ar_valid),
        .axi_in_ar_ready_o  (ar_ready_o),
        .axi_in_ar_id_i     (in_ar_id),
        .axi_in_ar_addr_i   (in_ar_addr),
        .axi_in_ar_prot_i   (3'd2),
        .axi_in_ar_region_i (4'd0),
        .axi_in_ar_len_i    (in_ar_len),
        .axi_in_ar_size_i   (3'd3),
        .axi_in_ar_burst_i  (2'd1),
        .axi_in_ar_lock_i   (1'b0),
        .axi_in_ar_cache_i  (4'd0),
        .axi_in_ar_qos_i    (4'd0),
        .axi_in_ar_user_i   (4'd0),
        .axi_out_ar_valid_o (ar_valid_o),
        .axi_out_ar_ready_i (out_ar_ready),
        .axi_out_ar_id_o    (ar_id_o),
        .axi_out_ar_addr_o  (ar_addr_o),
        .axi_out_ar_prot_o  (ar_prot_o),
        .axi_out_ar_region_o(ar_region_o),
        .axi_out_ar_len_o   (ar_len_o),
        .axi_out_ar_size_o  (ar_size_o),
        .axi_out_ar_burst_o (ar_burst_o),
        .axi_out_ar_lock_o  (ar_lock_o),
        .axi_out_ar_cache_o (ar_cache_o),
        .axi_out_ar_qos_o   (ar_qos_o),
        .axi_out_ar_user_o  (ar_user_o),
        .axi_out_r_valid_i  (out_r_valid),
        .axi_out_r_ready_o  (r_ready_o),
        .axi_out_r_id_i     (out_r_id),
        .axi_out_r_data_i   (out_r_data),
        .axi_out_r_resp_i   (out_r_resp),
        .axi_out_r_last_i   (out_r_last),
        .axi_out_r_user_i   (4'd0),
        .axi_in_r_valid_o   (r_valid_o),
        .axi_in_r_ready_i   (in_r_ready),
        .axi_in_r_id_o      (r_id_o),
        .axi_in_r_data_o    (r_data_o),
        .axi_in_r_resp_o    (r_resp_o),
        .axi_in_r_last_o    (r_last_o),
        .axi_in_r_user_o    (r_user_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: table of (in use, original ID, count) ----
    bit       m_used[NS];
    bit [6:0] m_orig[NS];
    int       m_cnt [NS];

    // Which slot would this ID go to, and may it go there now?
    function automatic void m_lookup(input bit [6:0] id, output bit acc, output int slot);
        acc  = 1'b0;
        slot = 0;
        for (int s = 0; s < NS; s++) begin
            if (m_used[s] && m_orig[s] == id) begin
                slot = s;
                acc  = (m_cnt[s] < MAX);
                return;
            end
        end
        for (int s = 0; s < NS; s++) begin
            if (!m_used[s]) begin
                slot = s;
                acc  = 1'b1;
                return;
            end
        end
    endfunction

    function automatic bit [6:0] m_rid(input bit [3:0] sid);
        if (sid < NS && m_used[sid]) return m_orig[sid];
        return '0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NS; s++) begin
                m_used[s] = 1'b0;
                m_orig[s] = '0;
                m_cnt[s]  = 0;
            end
        end else begin
            bit acc;
            int slot;
            bit r_done;
            m_lookup(in_ar_id, acc, slot);
            r_done = out_r_valid && in_r_ready && out_r_last && out_r_id < NS && m_used[out_r_id];
            if (in_ar_valid && out_ar_ready && acc) begin
                if (m_used[slot]) m_cnt[slot]++;
                else begin
                    m_used[slot] = 1'b1;
                    m_orig[slot] = in_ar_id;
                    m_cnt[slot]  = 1;
                end
            end
            if (r_done) begin
                m_cnt[out_r_id]--;
                if (m_cnt[out_r_id] == 0) m_used[out_r_id] = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bit acc;
        int slot;
        if (!rst_n) begin
            check("rst_ar_ready", ar_ready_o, out_ar_ready);
            check("rst_ar_valid", ar_valid_o, in_ar_valid);
        end else begin
            m_lookup(in_ar_id, acc, slot);
            check("ar_valid", ar_valid_o, in_ar_valid && acc);
            check("ar_ready", ar_ready_o, out_ar_ready && acc);
            if (in_ar_valid && acc) check("ar_id", ar_id_o, slot);
            check("ar_addr", ar_addr_o, in_ar_addr);
            check("ar_len", ar_len_o, in_ar_len);
            check("r_ready", r_ready_o, in_r_ready);
            check("r_valid", r_valid_o, out_r_valid);
            if (out_r_valid) begin
                check("r_id", r_id_o, m_rid(out_r_id));
                check("r_data", r_data_o, out_r_data);
                check("r_last", r_last_o, out_r_last);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Present an AR for up to max_wait cycles; reports whether and where it went.
    task automatic do_ar(input logic [6:0] id, input int max_wait,
                         output logic [3:0] oid, output bit ok);
        in_ar_valid = 1'b1;
        in_ar_id    = id;
        in_ar_addr  = {25'h0, id};
        in_ar_len   = 8'd3;
        ok  = 1'b0;
        oid = '0;
        for (int k = 0; k < max_wait; k++) begin
            @(negedge clk);
            if (ar_ready_o) begin
                oid = ar_id_o;
                ok  = 1'b1;
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        in_ar_valid = 1'b0;
    endtask

    task automatic ar_expect(input string name, input logic [6:0] id, input logic [3:0] exp);
        logic [3:0] oid;
        bit ok;
        do_ar(id, 5, oid, ok);
        check({name, "_accepted"}, ok, 1'b1);
        check({name, "_slot"}, oid, exp);
    endtask

    task automatic r_last_beat(input logic [3:0] sid);
        out_r_valid = 1'b1;
        out_r_id    = sid;
        out_r_last  = 1'b1;
        out_r_data  = 64'hD000 + sid;
        in_r_ready  = 1'b1;
        @(posedge clk);
        #1;
        out_r_valid = 1'b0;
        out_r_last  = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [3:0] oid;
        bit ok;
        int hs, cyc;

        do_reset();

        // Allocation and reuse
        ar_expect("id55_first", 7'h55, 4'd0);
        ar_expect("id55_second", 7'h55, 4'd0);
        check("model_cnt0_is_2", m_cnt[0], 2);
        ar_expect("id12", 7'h12, 4'd1);

        // Slot 1 burst of four beats, ready toggling 1010
        hs = 0;
        cyc = 0;
        out_r_valid = 1'b1;
        out_r_id = 4'd1;
        while (hs < 4 && cyc < 20) begin
            in_r_ready = (cyc % 2 == 0);
            out_r_last = (hs == 3);
            out_r_data = 64'hBEEF_0000 + 64'(hs);
            @(negedge clk);
            check("r_beat_id_0x12", r_id_o, 7'h12);
            @(posedge clk);
            if (in_r_ready) hs++;
            #1;
            cyc++;
        end
        check("r_beats_done", hs, 4);
        out_r_valid = 1'b0;
        out_r_last  = 1'b0;
        in_r_ready  = 1'b1;
        ar_expect("slot1_reused", 7'h20, 4'd1);

        // AR and R-last on slot 0 in the same cycle with one outstanding
        r_last_beat(4'd0);
        in_ar_valid = 1'b1;
        in_ar_id    = 7'h55;
        out_r_valid = 1'b1;
        out_r_id    = 4'd0;
        out_r_last  = 1'b1;
        @(negedge clk);
        check("same_cycle_ar_ready", ar_ready_o, 1'b1);
        check("same_cycle_ar_id", ar_id_o, 4'd0);
        @(posedge clk);
        #1;
        in_ar_valid = 1'b0;
        out_r_valid = 1'b0;
        out_r_last  = 1'b0;
        check("model_cnt0_kept_1", m_cnt[0], 1);
        r_last_beat(4'd0);
        ar_expect("slot0_freed_after_one_last", 7'h66, 4'd0);

        // Fill all slots, then a miss stalls until a slot frees
        do_reset();
        ar_expect("fill_01", 7'h01, 4'd0);
        ar_expect("fill_02", 7'h02, 4'd1);
        ar_expect("fill_03", 7'h03, 4'd2);
        ar_expect("fill_04", 7'h04, 4'd3);
        do_ar(7'h05, 3, oid, ok);
        check("full_miss_stalls", ok, 1'b0);
        in_ar_valid = 1'b1;
        in_ar_id    = 7'h05;
        out_r_valid = 1'b1;
        out_r_id    = 4'd2;
        out_r_last  = 1'b1;
        @(negedge clk);
        check("freed_slot_not_same_cycle", ar_ready_o, 1'b0);
        @(posedge clk);
        #1;
        out_r_valid = 1'b0;
        out_r_last  = 1'b0;
        @(negedge clk);
        check("id05_accepted_next_cycle", ar_ready_o, 1'b1);
        check("id05_slot", ar_id_o, 4'd2);
        @(posedge clk);
        #1;
        in_ar_valid = 1'b0;

        // Per-ID limit stalls even with free slots
        do_reset();
        for (int k = 0; k < MAX; k++) ar_expect("id7f_fill", 7'h7F, 4'd0);
        do_ar(7'h7F, 3, oid, ok);
        check("id7f_limit_stalls", ok, 1'b0);
        in_ar_valid = 1'b1;
        in_ar_id    = 7'h7F;
        out_r_valid = 1'b1;
        out_r_id    = 4'd0;
        out_r_last  = 1'b1;
        @(negedge clk);
        check("id7f_still_stalled", ar_ready_o, 1'b0);
        @(posedge clk);
        #1;
        out_r_valid = 1'b0;
        out_r_last  = 1'b0;
        @(negedge clk);
        check("id7f_accepted", ar_ready_o, 1'b1);
        check("id7f_slot", ar_id_o, 4'd0);
        @(posedge clk);
        #1;
        in_ar_valid = 1'b0;

        // Reset with slots in use clears the table
        do_reset();
        ar_expect("pre_rst_0a", 7'h0A, 4'd0);
        ar_expect("pre_rst_0b", 7'h0B, 4'd1);
        #2 rst_n = 1'b0;
        #1;
        check("in_reset_ar_ready", ar_ready_o, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ar_expect("post_rst_33", 7'h33, 4'd0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
